usb_ep_fifo_bank: RTL

USB_EP_FIFO_BANK -- requirements
Module: usb_ep_fifo_bank

---
 rtl/usb_ep_fifo_bank_if.sv | 30 +++
 rtl/usb_ep_fifo_bank.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/usb_ep_fifo_bank_if.sv
// ============================================================================
// Module      : usb_ep_fifo_bank_if
// Description : Shared write/read access bus of the endpoint FIFO bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface usb_ep_fifo_bank_if #(
    parameter int DATA_W = 8
) ();
    logic              we;
    logic [3:0]        wr_sel;
    logic [DATA_W-1:0] din;
    logic              re;
    logic [3:0]        rd_sel;
    logic [DATA_W-1:0] dout;
    logic              dout_vld;

    modport master (
        output we, wr_sel, din, re, rd_sel,
        input  dout, dout_vld
    );

    modport slave (
        input  we, wr_sel, din, re, rd_sel,
        output dout, dout_vld
    );
endinterface

`default_nettype wire

// File: rtl/usb_ep_fifo_bank.sv
// ============================================================================
// Module      : usb_ep_fifo_bank
// Description : Bank of NUM_EP independent circular endpoint FIFOs sharing one
//               write port and one registered read port, with per-EP
//               fill-threshold, overflow and underflow status.
//               Optional macro USB_EP_FIFO_FLUSH_EN enables the flush port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_ep_fifo_bank #(
    parameter  int NUM_EP = 7,
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 64,
    localparam int AW     = $clog2(DEPTH),
    localparam int LW     = AW + 1
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    usb_ep_fifo_bank_if.slave         bus,
    output logic [NUM_EP-1:0]         empty,
    output logic [NUM_EP-1:0]         full,
    output logic [NUM_EP*LW-1:0]      level,
    input  wire logic [NUM_EP-1:0]    bf_en,
    input  wire logic [NUM_EP*LW-1:0] bf_size,
    output logic [NUM_EP-1:0]         bf_hit,
    output logic [NUM_EP-1:0]         ovf,
    output logic [NUM_EP-1:0]         udf,
    input  wire logic [NUM_EP-1:0]    err_clr,
    input  wire logic [NUM_EP-1:0]    flush
);

    logic [NUM_EP-1:0]              w_flush;
    logic [NUM_EP-1:0]              w_rd_ok;
    logic [NUM_EP-1:0][DATA_W-1:0]  w_ep_word;
    logic                           w_rd_any;
    logic [DATA_W-1:0]              w_rd_data;
    logic [DATA_W-1:0]              r_dout;
    logic                           r_dout_vld;

`ifdef USB_EP_FIFO_FLUSH_EN
    assign w_flush = flush;
`else
    logic w_unused_flush;
    assign w_flush        = '0;
    assign w_unused_flush = ^flush;
`endif

    for (genvar i = 0; i < NUM_EP; i++) begin : g_ep
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [AW-1:0]     r_wptr;
        logic [AW-1:0]     r_rptr;
        logic [LW-1:0]     r_level;
        logic [LW-1:0]     w_level_nxt;
        logic              r_empty;
        logic              r_full;
        logic              r_ovf;
        logic              r_udf;
        logic              w_wr_hit;
        logic              w_rd_hit;
        logic              w_wr_ok;
        logic              w_rd_ok_ep;
        logic              w_ovf_set;
        logic              w_udf_set;

        assign w_wr_hit   = bus.we && (bus.wr_sel == 4'(i));
        assign w_rd_hit   = bus.re && (bus.rd_sel == 4'(i));
        // A full EP still accepts a write when the same cycle frees a slot.
        assign w_rd_ok_ep = w_rd_hit && !r_empty && !w_flush[i];
        assign w_wr_ok    = w_wr_hit && (!r_full || w_rd_ok_ep) && !w_flush[i];
        assign w_ovf_set  = w_wr_hit && r_full && !w_rd_ok_ep && !w_flush[i];
        assign w_udf_set  = w_rd_hit && r_empty && !w_flush[i];
        assign w_level_nxt = r_level + LW'(w_wr_ok) - LW'(w_rd_ok_ep);

        always_ff @(posedge clk) begin
            if (w_wr_ok) begin
                r_mem[r_wptr] <= bus.din;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
                r_empty <= 1'b1;
                r_full  <= 1'b0;
                r_ovf   <= 1'b0;
                r_udf   <= 1'b0;
            end else begin
                if (w_flush[i]) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_level <= '0;
                    r_empty <= 1'b1;
                    r_full  <= 1'b0;
                end else begin
                    if (w_wr_ok) begin
                        r_wptr <= r_wptr + AW'(1);
                    end
                    if (w_rd_ok_ep) begin
                        r_rptr <= r_rptr + AW'(1);
                    end
                    r_level <= w_level_nxt;
                    r_empty <= (w_level_nxt == '0);
                    r_full  <= (w_level_nxt == LW'(DEPTH));
                end
                // Set events take priority over a same-cycle clear.
                if (w_ovf_set) begin
                    r_ovf <= 1'b1;
                end else if (err_clr[i]) begin
                    r_ovf <= 1'b0;
                end
                if (w_udf_set) begin
                    r_udf <= 1'b1;
                end else if (err_clr[i]) begin
                    r_udf <= 1'b0;
                end
            end
        end

        assign w_rd_ok[i]          = w_rd_ok_ep;
        assign w_ep_word[i]        = r_mem[r_rptr];
        assign level[i*LW +: LW]   = r_level;
        assign empty[i]            = r_empty;
        assign full[i]             = r_full;
        assign ovf[i]              = r_ovf;
        assign udf[i]              = r_udf;
        assign bf_hit[i]           = bf_en[i] && (r_level >= bf_size[i*LW +: LW]);
    end

    always_comb begin
        w_rd_any  = |w_rd_ok;
        w_rd_data = '0;
        for (int k = 0; k < NUM_EP; k++) begin
            if (w_rd_ok[k]) begin
                w_rd_data = w_ep_word[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            r_dout_vld <= w_rd_any;
            if (w_rd_any) begin
                r_dout <= w_rd_data;
            end
        end
    end

    assign bus.dout     = r_dout;
    assign bus.dout_vld = r_dout_vld;

endmodule

`default_nettype wire
